decode_stage: RTL and testbench

Parametrised, pipelined successor to the single-instruction decoder. It decodes `LANES` instructions per cycle into a 7-bit control signal, a 32-bit immediate, a per-lane PC and an illegal flag. Results are held in a registered output stage with a two-entry skid buffer, so backpressure from rename/issue never combinationally reaches fetch. It sits between fetch and rename and supports a pipeline flush.

---
 rtl/decode_pkg.sv | 45 ++++
 rtl/decode_lane.sv | 97 +++++++++
 rtl/decode_stage.sv | 154 +++++++++++++++
 tb/tb_decode_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared constants and types for the multi-lane decode stage:
//   - RISC-V opcode and funct3 constants recognised by the decoder
//   - 7-bit control-signal encodings produced per lane
//   - lane_t: one decoded lane {valid, c_sig, imm, pc, illegal}
//   - sext12: sign-extension helper for 12-bit immediates
// The pc field is sized for the widest supported PC (PC_MAX_W); narrower
// instances use the low PC_W bits and leave the rest zero.
// -----------------------------------------------------------------------------
package decode_pkg;

    localparam int PC_MAX_W = 32;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] F3_BYTE  = 3'b000;
    localparam logic [2:0] F3_WORD  = 3'b010;

    localparam logic [6:0] SIG_NONE = 7'b0000000;
    localparam logic [6:0] SIG_R    = 7'b1000000;
    localparam logic [6:0] SIG_I    = 7'b1100000;
    localparam logic [6:0] SIG_LB   = 7'b1101011;
    localparam logic [6:0] SIG_LW   = 7'b1101010;
    localparam logic [6:0] SIG_SB   = 7'b0100101;
    localparam logic [6:0] SIG_SW   = 7'b0100100;
    localparam logic [6:0] SIG_LUI  = 7'b1100001;

    typedef struct packed {
        logic                valid;
        logic [6:0]          c_sig;
        logic [31:0]         imm;
        logic [PC_MAX_W-1:0] pc;
        logic                illegal;
    } lane_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/decode_lane.sv
// -----------------------------------------------------------------------------
// decode_lane
// Purely combinational single-instruction decoder.
// Ports:
//   instr [31:0]   instruction word
//   pc    [PC_W-1:0] PC of this lane
//   valid          lane valid; when 0 the whole decoded lane is zero
//   lane  (lane_t) decoded result {valid, c_sig, imm, pc, illegal}
// Build option: DECODE_LUI_EN makes LUI a legal instruction; otherwise LUI
// is reported as illegal.
// -----------------------------------------------------------------------------
module decode_lane
    import decode_pkg::*;
#(
    parameter int PC_W = 12
) (
    input  logic [31:0]     instr,
    input  logic [PC_W-1:0] pc,
    input  logic            valid,
    output lane_t           lane
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];

`ifndef DECODE_LUI_EN
    // rs1 field only matters to the LUI immediate, which is absent here
    logic unused_rs1_s;
    assign unused_rs1_s = ^instr[19:15];
`endif

    // Decode opcode/funct3 into control signal, immediate and illegal flag
    always_comb begin
        lane = '0;
        if (valid) begin
            lane.valid = 1'b1;
            lane.pc    = PC_MAX_W'(pc);
            case (opcode_s)
                OP_R: begin
                    lane.c_sig = SIG_R;
                end
                OP_I: begin
                    lane.c_sig = SIG_I;
                    lane.imm   = sext12(instr[31:20]);
                end
                OP_LOAD: begin
                    case (funct3_s)
                        F3_BYTE: begin
                            lane.c_sig = SIG_LB;
                            lane.imm   = sext12(instr[31:20]);
                        end
                        F3_WORD: begin
                            lane.c_sig = SIG_LW;
                            lane.imm   = sext12(instr[31:20]);
                        end
                        default: begin
                            lane.illegal = 1'b1;
                        end
                    endcase
                end
                OP_STORE: begin
                    case (funct3_s)
                        F3_BYTE: begin
                            lane.c_sig = SIG_SB;
                            lane.imm   = sext12({instr[31:25], instr[11:7]});
                        end
                        F3_WORD: begin
                            lane.c_sig = SIG_SW;
                            lane.imm   = sext12({instr[31:25], instr[11:7]});
                        end
                        default: begin
                            lane.illegal = 1'b1;
                        end
                    endcase
                end
                OP_LUI: begin
`ifdef DECODE_LUI_EN
                    lane.c_sig = SIG_LUI;
                    lane.imm   = {instr[31:12], 12'h000};
`else
                    lane.c_sig   = SIG_NONE;
                    lane.illegal = 1'b1;
`endif
                end
                default: begin
                    lane.illegal = 1'b1;
                end
            endcase
        end else begin
            lane = '0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Decodes LANES instructions per bundle and holds results in a registered
// main entry (M) backed by a skid entry (S) so out_ready never reaches
// in_ready combinationally.
// Parameters: LANES (1..4), PC_W (PC width).
// Ports:
//   clk, rst_n (async active-low), flush (drops M and S)
//   in_valid/in_ready, in_lane_valid[LANES], pc_in[PC_W], instr_in[LANES*32]
//   out_valid/out_ready, out_lane_valid[LANES], c_sig_out[LANES*7],
//   imm_out[LANES*32], pc_out[LANES*PC_W], illegal_out[LANES]
// Build option: DECODE_LUI_EN (passed through to decode_lane) enables LUI.
// -----------------------------------------------------------------------------
module decode_stage
    import decode_pkg::*;
#(
    parameter int LANES = 2,
    parameter int PC_W  = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      in_lane_valid,
    input  logic [PC_W-1:0]       pc_in,
    input  logic [LANES*32-1:0]   instr_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_lane_valid,
    output logic [LANES*7-1:0]    c_sig_out,
    output logic [LANES*32-1:0]   imm_out,
    output logic [LANES*PC_W-1:0] pc_out,
    output logic [LANES-1:0]      illegal_out
);

    lane_t [LANES-1:0]           dec_s;
    lane_t [LANES-1:0]           m_data_r;
    lane_t [LANES-1:0]           s_data_r;
    logic  [LANES-1:0][PC_W-1:0] pc_lane_s;

    logic m_valid_r;
    logic s_valid_r;
    logic in_ready_r;

    logic in_xfer_s;
    logic out_xfer_s;
    logic m_from_in_s;
    logic m_from_s_s;
    logic s_from_in_s;
    logic m_valid_s;
    logic s_valid_s;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            // Lane PC wraps naturally at PC_W bits
            assign pc_lane_s[g] = pc_in + PC_W'(4 * g);

            decode_lane #(
                .PC_W (PC_W)
            ) u_lane (
                .instr (instr_in[32*g +: 32]),
                .pc    (pc_lane_s[g]),
                .valid (in_lane_valid[g]),
                .lane  (dec_s[g])
            );

            assign out_lane_valid[g]         = m_data_r[g].valid;
            assign c_sig_out[7*g +: 7]       = m_data_r[g].c_sig;
            assign imm_out[32*g +: 32]       = m_data_r[g].imm;
            assign pc_out[PC_W*g +: PC_W]    = m_data_r[g].pc[PC_W-1:0];
            assign illegal_out[g]            = m_data_r[g].illegal;

            if (PC_W < PC_MAX_W) begin : g_pc_hi
                // Upper pc bits are always zero for narrow PCs
                logic unused_pc_hi_s;
                assign unused_pc_hi_s = ^m_data_r[g].pc[PC_MAX_W-1:PC_W];
            end
        end
    endgenerate

    assign out_valid = m_valid_r;
    assign in_ready  = in_ready_r;

    // Skid-buffer steering: decide where an accepted bundle lands and how
    // the valid bits evolve; flush overrides everything.
    always_comb begin
        in_xfer_s   = in_valid & in_ready_r;
        out_xfer_s  = m_valid_r & out_ready;
        m_from_in_s = 1'b0;
        m_from_s_s  = 1'b0;
        s_from_in_s = 1'b0;
        m_valid_s   = m_valid_r;
        s_valid_s   = s_valid_r;
        if (flush) begin
            m_valid_s = 1'b0;
            s_valid_s = 1'b0;
        end else if (out_xfer_s && s_valid_r) begin
            // in_ready was low, so no input can arrive in this cycle
            m_from_s_s = 1'b1;
            m_valid_s  = 1'b1;
            s_valid_s  = 1'b0;
        end else if (in_xfer_s && (!m_valid_r || out_xfer_s)) begin
            m_from_in_s = 1'b1;
            m_valid_s   = 1'b1;
        end else if (in_xfer_s) begin
            s_from_in_s = 1'b1;
            s_valid_s   = 1'b1;
        end else if (out_xfer_s) begin
            m_valid_s = 1'b0;
        end else begin
            m_valid_s = m_valid_r;
        end
    end

    // Valid bits and the registered in_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_r  <= 1'b0;
            s_valid_r  <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            m_valid_r  <= m_valid_s;
            s_valid_r  <= s_valid_s;
            in_ready_r <= !s_valid_s;
        end
    end

    // Main entry data: loads only on a write into M, otherwise holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_r <= '0;
        end else if (m_from_s_s) begin
            m_data_r <= s_data_r;
        end else if (m_from_in_s) begin
            m_data_r <= dec_s;
        end else begin
            m_data_r <= m_data_r;
        end
    end

    // Skid entry data: captures a bundle arriving while M is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_data_r <= '0;
        end else if (s_from_in_s) begin
            s_data_r <= dec_s;
        end else begin
            s_data_r <= s_data_r;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    localparam int LANES = 2;
    localparam int PC_W  = 12;

    logic                  clk;
    logic                  rst_n;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES-1:0]      in_lane_valid;
    logic [PC_W-1:0]       pc_in;
    logic [LANES*32-1:0]   instr_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES-1:0]      out_lane_valid;
    logic [LANES*7-1:0]    c_sig_out;
    logic [LANES*32-1:0]   imm_out;
    logic [LANES*PC_W-1:0] pc_out;
    logic [LANES-1:0]      illegal_out;

    decode_stage #(.LANES(LANES), .PC_W(PC_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_lane_valid  (in_lane_valid),
        .pc_in          (pc_in),
        .instr_in       (instr_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_lane_valid (out_lane_valid),
        .c_sig_out      (c_sig_out),
        .imm_out        (imm_out),
        .pc_out         (pc_out),
        .illegal_out    (illegal_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  lv;
        logic [13:0] sig;
        logic [63:0] imm;
        logic [23:0] pco;
        logic [1:0]  ill;
    } exp_t;

    typedef struct {
        logic [11:0] pc;
        logic [63:0] instr;
        logic [1:0]  lv;
        exp_t        e;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs[7];
    exp_t q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_bundle(input string tag, input exp_t e);
        check({tag, " lane_valid"}, 128'(out_lane_valid), 128'(e.lv));
        check({tag, " c_sig"},      128'(c_sig_out),      128'(e.sig));
        check({tag, " imm"},        128'(imm_out),        128'(e.imm));
        check({tag, " pc"},         128'(pc_out),         128'(e.pco));
        check({tag, " illegal"},    128'(illegal_out),    128'(e.ill));
    endtask

    // Reference decode of one instruction: {illegal, sig[6:0], imm[31:0]}
    function automatic logic [39:0] ref_lane(input logic [31:0] ins);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        op    = ins[6:0];
        f3    = ins[14:12];
        imm_i = 32'($signed(ins) >>> 20);
        imm_s = (32'($signed(ins) >>> 25) << 5) | ((ins >> 7) & 32'd31);
        if (op == 7'h33) return {1'b0, 7'b1000000, 32'd0};
        if (op == 7'h13) return {1'b0, 7'b1100000, imm_i};
        if (op == 7'h03 && f3 == 3'd0) return {1'b0, 7'b1101011, imm_i};
        if (op == 7'h03 && f3 == 3'd2) return {1'b0, 7'b1101010, imm_i};
        if (op == 7'h23 && f3 == 3'd0) return {1'b0, 7'b0100101, imm_s};
        if (op == 7'h23 && f3 == 3'd2) return {1'b0, 7'b0100100, imm_s};
`ifdef DECODE_LUI_EN
        if (op == 7'h37) return {1'b0, 7'b1100001, ins & 32'hFFFFF000};
`endif
        return {1'b1, 7'd0, 32'd0};
    endfunction

    function automatic exp_t ref_bundle(input logic [11:0] pc, input logic [63:0] ins, input logic [1:0] lv);
        exp_t e;
        logic [39:0] r;
        e = '0;
        e.lv = lv;
        for (int i = 0; i < LANES; i++) begin
            if (lv[i]) begin
                r = ref_lane(ins[32*i +: 32]);
                e.ill[i]          = r[39];
                e.sig[7*i +: 7]   = r[38:32];
                e.imm[32*i +: 32] = r[31:0];
                e.pco[12*i +: 12] = 12'((int'(pc) + 4 * i) % 4096);
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 5))
            0: x[6:0] = 7'h33;
            1: x[6:0] = 7'h13;
            2: begin x[6:0] = 7'h03; if ($urandom_range(0, 2) != 0) x[14:12] = 3'($urandom_range(0, 1) * 2); end
            3: begin x[6:0] = 7'h23; if ($urandom_range(0, 2) != 0) x[14:12] = 3'($urandom_range(0, 1) * 2); end
            4: x[6:0] = 7'h37;
            default: ;
        endcase
        return x;
    endfunction

    task automatic drive(input logic v, input vec_t t);
        in_valid      = v;
        pc_in         = t.pc;
        instr_in      = t.instr;
        in_lane_valid = t.lv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_empty_outputs(input string tag);
        check({tag, " out_valid"}, 128'(out_valid), 128'(0));
        check({tag, " in_ready"},  128'(in_ready),  128'(1));
        check_bundle(tag, exp_t'(0));
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_lane_valid = '0; pc_in = '0; instr_in = '0;

        vecs[0] = '{12'h100, {32'h0020A423, 32'hFFF00093}, 2'b11,
                    '{2'b11, 14'h1260, {32'h00000008, 32'hFFFFFFFF}, {12'h104, 12'h100}, 2'b00}};
        vecs[1] = '{12'h200, {32'hFFF00093, 32'h00001003}, 2'b01,
                    '{2'b01, 14'h0000, 64'h0, {12'h000, 12'h200}, 2'b01}};
        vecs[2] = '{12'h300, {32'hFFC12103, 32'h00408083}, 2'b11,
                    '{2'b11, 14'h356B, {32'hFFFFFFFC, 32'h00000004}, {12'h304, 12'h300}, 2'b00}};
        vecs[3] = '{12'h010, {32'h002081B3, 32'hFE000FA3}, 2'b11,
                    '{2'b11, 14'h2025, {32'h00000000, 32'hFFFFFFFF}, {12'h014, 12'h010}, 2'b00}};
        vecs[4] = '{12'hFFC, {32'h00000033, 32'h00000033}, 2'b11,
                    '{2'b11, 14'h2040, 64'h0, {12'h000, 12'hFFC}, 2'b00}};
`ifdef DECODE_LUI_EN
        vecs[5] = '{12'h000, {32'h00001023, 32'h123452B7}, 2'b11,
                    '{2'b11, 14'h0061, {32'h00000000, 32'h12345000}, {12'h004, 12'h000}, 2'b10}};
`else
        vecs[5] = '{12'h000, {32'h00001023, 32'h123452B7}, 2'b11,
                    '{2'b11, 14'h0000, 64'h0, {12'h004, 12'h000}, 2'b11}};
`endif
        vecs[6] = '{12'h400, {32'h0000007F, 32'h0000007F}, 2'b10,
                    '{2'b10, 14'h0000, 64'h0, {12'h404, 12'h000}, 2'b10}};

        // Reset state
        tick();
        tick();
        check_empty_outputs("reset");
        rst_n = 1'b1;

        // Table-driven decode, one bundle per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, vecs[i]);
            tick();
            check($sformatf("vec%0d out_valid", i), 128'(out_valid), 128'(1));
            check($sformatf("vec%0d in_ready", i), 128'(in_ready), 128'(1));
            check_bundle($sformatf("vec%0d", i), vecs[i].e);
        end
        in_valid = 1'b0;
        tick();
        check("drain out_valid", 128'(out_valid), 128'(0));

        // Backpressure: A, B, C with out_ready low
        out_ready = 1'b0;
        drive(1'b1, vecs[0]); tick();
        check("bp A in_ready", 128'(in_ready), 128'(1));
        check_bundle("bp A", vecs[0].e);
        drive(1'b1, vecs[2]); tick();
        check("bp full in_ready", 128'(in_ready), 128'(0));
        drive(1'b1, vecs[3]); tick();
        check("bp stall in_ready", 128'(in_ready), 128'(0));
        check("bp stall out_valid", 128'(out_valid), 128'(1));
        check_bundle("bp stall", vecs[0].e);
        tick();
        check_bundle("bp hold", vecs[0].e);
        out_ready = 1'b1; tick();
        check("bp B in_ready", 128'(in_ready), 128'(1));
        check_bundle("bp B", vecs[2].e);
        tick();
        check("bp C out_valid", 128'(out_valid), 128'(1));
        check_bundle("bp C", vecs[3].e);
        in_valid = 1'b0; tick();
        check("bp empty out_valid", 128'(out_valid), 128'(0));

        // Flush with M and S full plus a simultaneous input
        out_ready = 1'b0;
        drive(1'b1, vecs[0]); tick();
        drive(1'b1, vecs[2]); tick();
        drive(1'b1, vecs[3]); flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush full out_valid", 128'(out_valid), 128'(0));
        check("flush full in_ready", 128'(in_ready), 128'(1));
        tick();
        check("flush full after", 128'(out_valid), 128'(0));

        // Flush while an input transfer is accepted: the input is discarded
        drive(1'b1, vecs[4]); tick();
        drive(1'b1, vecs[5]); flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush xfer out_valid", 128'(out_valid), 128'(0));
        tick();
        check("flush xfer after", 128'(out_valid), 128'(0));

        // Asynchronous reset mid-stream with both entries full
        drive(1'b1, vecs[0]); tick();
        drive(1'b1, vecs[2]); tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_empty_outputs("async rst");
        tick();
        rst_n = 1'b1;
        tick();
        check("post rst out_valid", 128'(out_valid), 128'(0));

        // Randomised traffic against a queue model of the two-entry buffer
        q.delete();
        for (int n = 0; n < 600; n++) begin
            logic ix;
            logic ox;
            logic fl;
            exp_t e;
            in_valid      = ($urandom_range(0, 3) != 0);
            in_lane_valid = 2'($urandom_range(0, 3));
            pc_in         = 12'($urandom_range(0, 4095));
            instr_in      = {gen_instr(), gen_instr()};
            out_ready     = ($urandom_range(0, 2) != 0);
            fl            = ($urandom_range(0, 24) == 0);
            flush         = fl;
            ix = in_valid && (q.size() < 2);
            ox = (q.size() > 0) && out_ready;
            e  = ref_bundle(pc_in, instr_in, in_lane_valid);
            tick();
            if (fl) begin
                q.delete();
            end else begin
                if (ox) void'(q.pop_front());
                if (ix) q.push_back(e);
            end
            check("rnd out_valid", 128'(out_valid), 128'(q.size() > 0));
            check("rnd in_ready", 128'(in_ready), 128'(q.size() < 2));
            if (q.size() > 0) check_bundle("rnd", q[0]);
        end
        flush = 1'b0;
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
